// File: rtl/inst_encoder.sv
// Packs decoded RV32 fields (I/S/B/R) into a 32-bit instruction word and
// buffers {err,inst} in a small output FIFO with valid/ready on both sides.
module inst_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] TYPE_I = 2'd0;
  localparam logic [1:0] TYPE_S = 2'd1;
  localparam logic [1:0] TYPE_B = 2'd2;
  localparam logic [1:0] TYPE_R = 2'd3;

  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [32:0]      mem [FIFO_DEPTH];

  logic        full, empty, push, pop;
  logic [31:0] inst_next;
  logic        err_next;
  logic        imm_ovf;

  // In range iff bits [31:11] are all ones or all zeros.
  assign imm_ovf = !((&in_imm[31:11]) || !(|in_imm[31:11]));

  always_comb begin
    inst_next = 32'd0;
    err_next  = 1'b0;
    case (in_type)
      TYPE_I: begin
        inst_next = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        err_next  = imm_ovf;
      end
      TYPE_S: begin
        inst_next = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        err_next  = imm_ovf;
      end
      TYPE_B: begin
        // imm is already a halfword offset: bit 11 -> inst[31], bit 10 -> inst[7]
        inst_next = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                     in_imm[3:0], in_imm[10], in_opcode};
        err_next  = imm_ovf;
      end
      TYPE_R: begin
        inst_next = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        err_next  = 1'b0;
      end
      default: begin
        inst_next = 32'd0;
        err_next  = 1'b0;
      end
    endcase
  end

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  assign out_valid = !empty;
  assign out_inst  = empty ? 32'd0 : mem[rd_ptr_reg[AW-1:0]][31:0];
  assign out_err   = empty ? 1'b0  : mem[rd_ptr_reg[AW-1:0]][32];
  assign enc_count = count_reg;

  // Storage needs no reset: pointers alone decide what is visible.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem[gi] <= {err_next, inst_next};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        count_reg  <= count_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule
